fp_divsqrt_issue: RTL

Request sequencer directly upstream of fp_unit's execute port for f32 divide and square root. It buffers operand requests from a valid/ready producer in a small FIFO. It issues them one at a time as single-cycle enable pulses, waits for the unit's ready pulse, and returns the result and flags through a valid/ready response port. A watchdog converts a missing ready into a flagged timeout response.

---
 rtl/fp_divsqrt_issue.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/fp_divsqrt_issue.sv
// Request sequencer in front of fp_unit for f32 divide / square root: buffers requests,
// issues one at a time, and returns result/flags (or a watchdog timeout) over valid/ready.
module fp_divsqrt_issue #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [31:0]            req_data1,
  input  logic [31:0]            req_data2,
  input  logic [2:0]             req_rm,
  input  logic                   req_sqrt,
  input  logic [TAG_W-1:0]       req_tag,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic [31:0]            exe_data1,
  output logic [31:0]            exe_data2,
  output logic [31:0]            exe_data3,
  output logic [1:0]             exe_fmt,
  output logic [2:0]             exe_rm,
  output logic                   exe_fdiv,
  output logic                   exe_fsqrt,
  output logic                   exe_enable,
  input  logic [31:0]            exe_result,
  input  logic [4:0]             exe_flags,
  input  logic                   exe_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [31:0]            rsp_result,
  output logic [4:0]             rsp_flags,
  output logic [TAG_W-1:0]       rsp_tag,
  output logic                   rsp_timeout
);

  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned CNTW  = PW + 1;
  localparam int unsigned CW    = $clog2(TIMEOUT);
  localparam int unsigned TLAST = TIMEOUT - 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

  logic [31:0]      fa_q   [DEPTH];
  logic [31:0]      fb_q   [DEPTH];
  logic [2:0]       frm_q  [DEPTH];
  logic             fsq_q  [DEPTH];
  logic [TAG_W-1:0] ftag_q [DEPTH];

  logic [PW-1:0]    wr_q, rd_q;
  logic [CNTW-1:0]  count_q;
  logic             push, pop;

  state_e           state_q;
  logic [CW-1:0]    tmo_q, tmo_d;
  logic [31:0]      d1_q, d2_q;
  logic [2:0]       rm_q;
  logic             fdiv_q, fsqrt_q, en_q;
  logic [TAG_W-1:0] tag_q;
  logic             rsp_valid_q, rsp_timeout_q;
  logic [31:0]      rsp_result_q;
  logic [4:0]       rsp_flags_q;
  logic [TAG_W-1:0] rsp_tag_q;

  // Pop only when the response slot is free or being drained this cycle, so a
  // completion can never overwrite an unaccepted response.
  always_comb begin
    push  = 1'b0;
    pop   = 1'b0;
    push  = req_valid && req_ready;
    pop   = (state_q == S_IDLE) && (count_q != '0) && (!rsp_valid_q || rsp_ready);
    tmo_d = tmo_q + CW'(1);
  end

  assign req_ready = (count_q != CNTW'(DEPTH));
  assign occupancy = count_q;

  always_ff @(posedge clock) begin
    if (push) begin
      fa_q[wr_q]   <= req_data1;
      fb_q[wr_q]   <= req_data2;
      frm_q[wr_q]  <= req_rm;
      fsq_q[wr_q]  <= req_sqrt;
      ftag_q[wr_q] <= req_tag;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tmo_q         <= '0;
      d1_q          <= '0;
      d2_q          <= '0;
      rm_q          <= '0;
      fdiv_q        <= 1'b0;
      fsqrt_q       <= 1'b0;
      en_q          <= 1'b0;
      tag_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_result_q  <= '0;
      rsp_flags_q   <= '0;
      rsp_tag_q     <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pop) begin
            d1_q    <= fa_q[rd_q];
            d2_q    <= fsq_q[rd_q] ? '0 : fb_q[rd_q];
            rm_q    <= frm_q[rd_q];
            fsqrt_q <= fsq_q[rd_q];
            fdiv_q  <= !fsq_q[rd_q];
            tag_q   <= ftag_q[rd_q];
            en_q    <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          en_q    <= 1'b0;
          tmo_q   <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (exe_ready) begin
            rsp_result_q  <= exe_result;
            rsp_flags_q   <= exe_flags;
            rsp_tag_q     <= tag_q;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_IDLE;
          end else if (tmo_d == CW'(TLAST)) begin
            // Timeout fires as the incremented count reaches TIMEOUT-1.
            rsp_result_q  <= 32'h7FC0_0000;
            rsp_flags_q   <= '0;
            rsp_tag_q     <= tag_q;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            tmo_q <= tmo_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign exe_data1   = d1_q;
  assign exe_data2   = d2_q;
  assign exe_data3   = '0;
  assign exe_fmt     = '0;
  assign exe_rm      = rm_q;
  assign exe_fdiv    = fdiv_q;
  assign exe_fsqrt   = fsqrt_q;
  assign exe_enable  = en_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_flags   = rsp_flags_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule
